mem_stage_ctrl: RTL

//  Sequences the MEM stage: takes the access held in the EX/MEM pipeline register, runs a
//  req/ack handshake to a variable-latency data memory, and stalls the pipeline until it

---
 rtl/mem_stage_ctrl_if.sv | 38 +++
 rtl/mem_stage_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
//   Bundles the EX/MEM-side access signals, the pipeline stall/result signals
//   and the data-memory req/ack handshake used by mem_stage_ctrl.
//   slave  : the MEM-stage controller (mem_stage_ctrl)
//   master : the environment (EX/MEM register, MEM/WB register, data memory)
//   Signals:
//     mem_ctrl_i  [1]=MemRead [0]=MemWrite from EX/MEM
//     addr_i      byte address from EX/MEM
//     wdata_i     store data from EX/MEM
//     stall_o     freeze upstream pipeline registers
//     rdata_o     load data to MEM/WB
//     err_o       sticky timeout / misalignment flag
//     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o  request to data memory
//     mem_ack_i, mem_rdata_i                        response from data memory
interface mem_stage_ctrl_if;
  logic [1:0]  mem_ctrl_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  mem_ctrl_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    output stall_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output mem_ctrl_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    input  stall_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Sequences the MEM stage: issues the access held in EX/MEM to a
//   variable-latency data memory over a req/ack handshake and stalls the
//   upstream pipeline until it completes, times out, or is rejected as
//   misaligned.
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  asynchronous active-high reset
//     bus    mem_stage_ctrl_if.slave (access in, stall/result out, memory port)
//   Parameters:
//     TIMEOUT   BUSY cycles without ack before the access is aborted (>=2)
//     ALIGN_CHK 1: accesses with addr_i[1:0]!=0 are not issued and set err_o
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          ALIGN_CHK = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_stage_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pend;
  logic             aligned;

  always_comb begin
    pend    = |bus.mem_ctrl_i;
    aligned = !ALIGN_CHK || (bus.addr_i[1:0] == 2'b00);
  end

  // DONE deliberately releases the stall for one cycle so EX/MEM can advance.
  always_comb begin
    bus.stall_o = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE:    bus.stall_o = pend;
        BUSY:    bus.stall_o = 1'b1;
        default: bus.stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.rdata_o     <= '0;
      bus.err_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend) begin
            if (aligned) begin
              bus.mem_addr_o  <= bus.addr_i;
              bus.mem_wdata_o <= bus.wdata_i;
              // 2'b11 resolves to a write because bit 0 is MemWrite.
              bus.mem_we_o    <= bus.mem_ctrl_i[0];
              bus.mem_req_o   <= 1'b1;
              cnt             <= '0;
              state           <= BUSY;
            end else begin
              bus.err_o <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          // Ack is checked before the timeout so an ack on the last cycle wins.
          if (bus.mem_ack_i) begin
            bus.mem_req_o <= 1'b0;
            if (!bus.mem_we_o) begin
              bus.rdata_o <= bus.mem_rdata_i;
            end
            state <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.mem_req_o <= 1'b0;
            bus.err_o     <= 1'b1;
            if (!bus.mem_we_o) begin
              bus.rdata_o <= '0;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
